// File: rtl/rtc_cfg_pkg.sv
// Shared definitions for the RTC field chip-select sequencer.
//   - seq_state_e : sequencer states (idle / editing / one-cycle commit)
//   - GRP_*       : register group indices (hora, fecha, timer)
//   - MODE_NONE   : mode_sel value meaning "no edit requested"
//   - clog2       : width helper, never returns less than 1 so that
//                   single-entry parameters still give a legal vector
package rtc_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } seq_state_e;

  localparam int GRP_HORA  = 0;
  localparam int GRP_FECHA = 1;
  localparam int GRP_TIMER = 2;

  localparam int MODE_NONE = 0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/rtc_blink_timer.sv
// Blink phase generator for the field currently being edited.
// Ports:
//   clk_i     : system clock
//   reset_i   : synchronous active-high reset
//   en_i      : blink runs only while enabled; disabled holds phase low
//   restart_i : restart the blink period with the "on" phase
//   blink_o   : blink phase, toggles every BLINK_CYCLES enabled cycles
module rtc_blink_timer
  import rtc_cfg_pkg::*;
#(
  parameter int BLINK_CYCLES = 25000000,
  localparam int BW = clog2(BLINK_CYCLES)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic restart_i,
  output logic blink_o
);

  localparam logic [BW-1:0] CNT_LAST = BW'(BLINK_CYCLES - 1);

  logic [BW-1:0] cnt_q;
  logic          blink_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || !en_i) begin
      cnt_q   <= '0;
      blink_q <= 1'b0;
    end else if (restart_i) begin
      cnt_q   <= '0;
      blink_q <= 1'b1;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q   <= '0;
      blink_q <= ~blink_q;
    end else begin
      cnt_q <= cnt_q + BW'(1);
    end
  end

  assign blink_o = blink_q;

endmodule

// File: rtl/rtc_field_cs_sequencer.sv
// Registered field chip-select sequencer for the clock core configuration.
// Picks one register group from mode_sel, then walks its fields under
// next/prev pulses, driving a single field chip-select with a blink phase,
// a commit load strobe and an inactivity timeout.
//
// State table:
//   IDLE   | no edit; only the timer group may be selected (show_timer)
//   EDIT   | one field of the active group selected, blinking
//   COMMIT | one cycle, whole group selected with the commit strobe
//
// Ports:
//   clk          : system clock
//   reset        : synchronous active-high reset
//   mode_sel     : 0 = no edit, k = edit group k-1, > N_GROUPS treated as 0
//   show_timer   : timer group displayed/counting (level)
//   field_next   : pulse, advance to next field (wraps)
//   field_prev   : pulse, retreat to previous field (wraps)
//   edit_done    : pulse, commit and leave edit
//   cs           : chip-selects, bit g*N_FIELDS+f = field f of group g
//   active_group : group being edited (0 when idle)
//   active_field : field being edited (0 when idle)
//   editing      : high while in EDIT
//   blink        : blink phase for the active field display
//   commit       : one-cycle commit pulse
//   timeout_evt  : one-cycle pulse when an edit is abandoned on inactivity
module rtc_field_cs_sequencer
  import rtc_cfg_pkg::*;
#(
  parameter int N_GROUPS       = 3,
  parameter int N_FIELDS       = 3,
  parameter int TIMER_GROUP    = GRP_TIMER,
  parameter int BLINK_CYCLES   = 25000000,
  parameter int TIMEOUT_CYCLES = 500000000,
  localparam int MODE_W = clog2(N_GROUPS + 1),
  localparam int GW     = clog2(N_GROUPS),
  localparam int FW     = clog2(N_FIELDS),
  localparam int CS_W   = N_GROUPS * N_FIELDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MODE_W-1:0] mode_sel,
  input  logic              show_timer,
  input  logic              field_next,
  input  logic              field_prev,
  input  logic              edit_done,
  output logic [CS_W-1:0]   cs,
  output logic [GW-1:0]     active_group,
  output logic [FW-1:0]     active_field,
  output logic              editing,
  output logic              blink,
  output logic              commit,
  output logic              timeout_evt
);

  localparam int TW = clog2(TIMEOUT_CYCLES);

  function automatic logic [CS_W-1:0] group_mask(input logic [GW-1:0] g);
    logic [CS_W-1:0] m;
    m = '0;
    for (int f = 0; f < N_FIELDS; f++) begin
      m = m | (CS_W'(1) << (int'(g) * N_FIELDS + f));
    end
    return m;
  endfunction

  function automatic logic [CS_W-1:0] field_onehot(input logic [GW-1:0] g,
                                                   input logic [FW-1:0] f);
    return CS_W'(1) << (int'(g) * N_FIELDS + int'(f));
  endfunction

  localparam logic [TW-1:0]   TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0]   FIELD_LAST = FW'(N_FIELDS - 1);
  localparam logic [GW-1:0]   TIMER_GRP  = GW'(TIMER_GROUP);
  localparam logic [CS_W-1:0] TIMER_MASK = group_mask(GW'(TIMER_GROUP));

  seq_state_e      state_q,   state_d;
  logic [GW-1:0]   group_q,   group_d;
  logic [FW-1:0]   field_q,   field_d;
  logic            rearm_q,   rearm_d;
  logic [TW-1:0]   tmo_q,     tmo_d;
  logic [CS_W-1:0] cs_q,      cs_d;
  logic            commit_q,  commit_d;
  logic            timeout_q, timeout_d;
  logic            editing_q, editing_d;
  logic            blink_restart;

  // Widen before range-checking so invalid codes are caught for any
  // N_GROUPS, including when MODE_W cannot represent an invalid value.
  logic [31:0]     mode_ext;
  logic            mode_valid;
  logic [GW-1:0]   mode_grp;
  logic [CS_W-1:0] timer_bits;

  assign mode_ext   = 32'(mode_sel);
  assign mode_valid = (mode_ext != 32'(MODE_NONE)) && (mode_ext <= 32'(N_GROUPS));
  assign mode_grp   = GW'(mode_ext - 32'd1);
  assign timer_bits = show_timer ? TIMER_MASK : '0;

  always_comb begin
    state_d       = state_q;
    group_d       = group_q;
    field_d       = field_q;
    rearm_d       = rearm_q;
    tmo_d         = tmo_q;
    cs_d          = '0;
    commit_d      = 1'b0;
    timeout_d     = 1'b0;
    editing_d     = 1'b0;
    blink_restart = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (mode_valid && rearm_q) begin
          state_d       = ST_EDIT;
          group_d       = mode_grp;
          field_d       = '0;
          blink_restart = 1'b1;
        end else begin
          group_d = '0;
          field_d = '0;
          if (!mode_valid) rearm_d = 1'b1;
        end
      end

      ST_EDIT: begin
        if (edit_done || !mode_valid) begin
          // Commit wins over a same-cycle step or an expiring timeout.
          state_d  = ST_COMMIT;
          commit_d = 1'b1;
          tmo_d    = '0;
        end else if (mode_grp != group_q) begin
          group_d       = mode_grp;
          field_d       = '0;
          tmo_d         = '0;
          blink_restart = 1'b1;
        end else if (field_next || field_prev) begin
          // Both pulses together still count as activity but cancel out.
          tmo_d         = '0;
          blink_restart = 1'b1;
          if (field_next && !field_prev) begin
            field_d = (field_q == FIELD_LAST) ? '0 : field_q + FW'(1);
          end else if (field_prev && !field_next) begin
            field_d = (field_q == '0) ? FIELD_LAST : field_q - FW'(1);
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
          rearm_d   = 1'b0;
          group_d   = '0;
          field_d   = '0;
          tmo_d     = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ST_COMMIT: begin
        state_d = ST_IDLE;
        group_d = '0;
        field_d = '0;
        tmo_d   = '0;
        rearm_d = !mode_valid;
      end

      default: begin
        state_d = ST_IDLE;
        group_d = '0;
        field_d = '0;
        tmo_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they land in the same
    // cycle as the state they describe.
    case (state_d)
      ST_EDIT: begin
        editing_d = 1'b1;
        cs_d      = field_onehot(group_d, field_d);
        if (group_d != TIMER_GRP) cs_d = cs_d | timer_bits;
      end
      ST_COMMIT: cs_d = group_mask(group_d) | timer_bits;
      default:   cs_d = timer_bits;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      group_q   <= '0;
      field_q   <= '0;
      rearm_q   <= 1'b1;
      tmo_q     <= '0;
      cs_q      <= '0;
      commit_q  <= 1'b0;
      timeout_q <= 1'b0;
      editing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      group_q   <= group_d;
      field_q   <= field_d;
      rearm_q   <= rearm_d;
      tmo_q     <= tmo_d;
      cs_q      <= cs_d;
      commit_q  <= commit_d;
      timeout_q <= timeout_d;
      editing_q <= editing_d;
    end
  end

  rtc_blink_timer #(
    .BLINK_CYCLES(BLINK_CYCLES)
  ) u_blink (
    .clk_i     (clk),
    .reset_i   (reset),
    .en_i      (state_d == ST_EDIT),
    .restart_i (blink_restart),
    .blink_o   (blink)
  );

  assign cs           = cs_q;
  assign active_group = group_q;
  assign active_field = field_q;
  assign editing      = editing_q;
  assign commit       = commit_q;
  assign timeout_evt  = timeout_q;

endmodule
